clkdiv_gen: RTL and testbench

Programmable clock-event generator that sits directly upstream of the edge-sensitive timing consumers. It derives a divided clock `clk_out` from the core clock, plus single-cycle rising and falling edge strobes. It counts `clk_out` periods and stops cleanly after a programmed number of cycles with a `done` flag. Consumers can trigger on `clk_out` edges, both edges, or the strobes.

---
 rtl/clkdiv_pkg.sv | 13 +
 rtl/clkdiv_gen.sv | 97 +++++++++
 tb/tb_clkdiv_gen.sv | 179 +++++++++++++++++
 3 files changed

// File: rtl/clkdiv_pkg.sv
// rtl/clkdiv_pkg.sv - shared state encoding and default widths for clkdiv_gen
package clkdiv_pkg;

  localparam int CNT_W_DEF = 8;
  localparam int CYC_W_DEF = 16;

  typedef enum logic [1:0] {
    IDLE,
    RUN,
    DONE
  } clkdiv_state_e;

endpackage

// File: rtl/clkdiv_gen.sv
// rtl/clkdiv_gen.sv - divided clock with edge strobes, period counter and cycle limit
module clkdiv_gen
  import clkdiv_pkg::*;
#(
  parameter int CNT_W = CNT_W_DEF,
  parameter int CYC_W = CYC_W_DEF
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             en,
  input  logic [CNT_W-1:0] div_half,
  input  logic [CYC_W-1:0] max_cyc,
  output logic             clk_out,
  output logic             pos_stb,
  output logic             neg_stb,
  output logic [CYC_W-1:0] cyc,
  output logic             done
);

  clkdiv_state_e    state;
  logic [CNT_W-1:0] cnt_q;
  logic [CNT_W-1:0] half_q;
  logic [CYC_W-1:0] lim_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state   <= IDLE;
      clk_out <= 1'b0;
      pos_stb <= 1'b0;
      neg_stb <= 1'b0;
      cyc     <= '0;
      done    <= 1'b0;
      cnt_q   <= '0;
      half_q  <= '0;
      lim_q   <= '0;
    end else begin
      pos_stb <= 1'b0;
      neg_stb <= 1'b0;
      case (state)
        IDLE: begin
          clk_out <= 1'b0;
          done    <= 1'b0;
          if (en) begin
            // Zero-latency start: the sampling edge is already the first rising edge.
            half_q  <= (div_half == '0) ? CNT_W'(1) : div_half;
            lim_q   <= max_cyc;
            cnt_q   <= '0;
            clk_out <= 1'b1;
            pos_stb <= 1'b1;
            cyc     <= CYC_W'(1);
            state   <= RUN;
          end
        end

        RUN: begin
          if (cnt_q == half_q - CNT_W'(1)) begin
            cnt_q <= '0;
            if (clk_out) begin
              clk_out <= 1'b0;
              neg_stb <= 1'b1;
              // Limit check outranks a dropped en so the final period is reported.
              if ((lim_q != '0) && (cyc == lim_q)) begin
                done  <= 1'b1;
                state <= DONE;
              end else if (!en) begin
                state <= IDLE;
              end
            end else if (!en) begin
              state <= IDLE;
            end else begin
              clk_out <= 1'b1;
              pos_stb <= 1'b1;
              if (cyc != '1) begin
                cyc <= cyc + CYC_W'(1);
              end
            end
          end else begin
            cnt_q <= cnt_q + CNT_W'(1);
          end
        end

        DONE: begin
          clk_out <= 1'b0;
          if (!en) begin
            done  <= 1'b0;
            state <= IDLE;
          end
        end

        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_clkdiv_gen.sv
// tb/tb_clkdiv_gen.sv - randomized and directed checks of clkdiv_gen against a period-arithmetic model
module tb_clkdiv_gen;

  localparam int INF = 1 << 28;

  logic        clk;
  logic        rst_n;
  logic        en;
  logic        en4;
  logic [7:0]  div_half;
  logic [15:0] max_cyc;
  logic [3:0]  max4;

  logic        clk_out, pos_stb, neg_stb, done;
  logic [15:0] cyc;
  logic        clk_out4, pos_stb4, neg_stb4, done4;
  logic [3:0]  cyc4;

  int total = 0;
  int bad   = 0;

  clkdiv_gen dut (
    .clk(clk), .rst_n(rst_n), .en(en), .div_half(div_half), .max_cyc(max_cyc),
    .clk_out(clk_out), .pos_stb(pos_stb), .neg_stb(neg_stb), .cyc(cyc), .done(done)
  );

  clkdiv_gen #(.CNT_W(8), .CYC_W(4)) dut4 (
    .clk(clk), .rst_n(rst_n), .en(en4), .div_half(div_half), .max_cyc(max4),
    .clk_out(clk_out4), .pos_stb(pos_stb4), .neg_stb(neg_stb4), .cyc(cyc4), .done(done4)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input int obs, input int exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  function automatic int sat(input int v, input int cmax);
    return (v > cmax) ? cmax : v;
  endfunction

  // Expected outputs k edges after the start edge. The run is a train of
  // 2h-cycle periods, cut short either by the cycle limit or by en sampled low
  // from edge d onward (the cut lands on the next multiple of h).
  task automatic model(input int k, input int h, input int lim, input int d, input int cmax,
                       output int eclk, output int epos, output int eneg,
                       output int edone, output int ecyc);
    int h2, kdone, stop_s, endk, clr;
    bit donewin;
    h2      = 2 * h;
    kdone   = (lim != 0) ? (2 * lim - 1) * h : INF;
    stop_s  = ((d + h - 1) / h) * h;
    donewin = (kdone <= stop_s);
    endk    = donewin ? kdone : stop_s;
    clr     = (kdone + 1 > d) ? kdone + 1 : d;
    eclk = 0; epos = 0; eneg = 0; edone = 0; ecyc = 0;
    if (k < endk) begin
      eclk = ((k % h2) < h) ? 1 : 0;
      epos = ((k % h2) == 0) ? 1 : 0;
      eneg = ((k % h2) == h) ? 1 : 0;
      ecyc = sat(k / h2 + 1, cmax);
    end else if (donewin) begin
      ecyc  = lim;
      eneg  = (k == endk) ? 1 : 0;
      edone = (k < clr) ? 1 : 0;
    end else begin
      if ((endk % h2) == h) ecyc = sat(endk / h2 + 1, cmax);
      else                  ecyc = sat(endk / h2, cmax);
      eneg = ((k == endk) && ((endk % h2) == h)) ? 1 : 0;
    end
  endtask

  task automatic run_case(input bit narrow, input int div, input int lim, input int d, input int n);
    int h, eclk, epos, eneg, edone, ecyc;
    h = (div == 0) ? 1 : div;
    @(negedge clk);
    div_half = 8'(div);
    max_cyc  = 16'(lim);
    max4     = 4'(lim);
    if (narrow) en4 = 1'b1; else en = 1'b1;
    for (int k = 0; k < n; k++) begin
      @(posedge clk);
      #1;
      model(k, h, lim, d, narrow ? 15 : 65535, eclk, epos, eneg, edone, ecyc);
      if (narrow) begin
        chk("clk_out4", int'(clk_out4), eclk);
        chk("pos_stb4", int'(pos_stb4), epos);
        chk("neg_stb4", int'(neg_stb4), eneg);
        chk("done4",    int'(done4),    edone);
        chk("cyc4",     int'(cyc4),     ecyc);
      end else begin
        chk("clk_out", int'(clk_out), eclk);
        chk("pos_stb", int'(pos_stb), epos);
        chk("neg_stb", int'(neg_stb), eneg);
        chk("done",    int'(done),    edone);
        chk("cyc",     int'(cyc),     ecyc);
      end
      // Programming inputs are ignored once running.
      div_half = 8'($urandom_range(0, 255));
      max_cyc  = 16'($urandom_range(0, 65535));
      max4     = 4'($urandom_range(0, 15));
      if (k + 1 == d) begin
        en  = 1'b0;
        en4 = 1'b0;
      end
    end
    en  = 1'b0;
    en4 = 1'b0;
    repeat (3) @(posedge clk);
  endtask

  initial begin
    rst_n    = 1'b0;
    en       = 1'b0;
    en4      = 1'b0;
    div_half = '0;
    max_cyc  = '0;
    max4     = '0;
    #12;
    chk("rst_clk_out", int'(clk_out), 0);
    chk("rst_done",    int'(done),    0);
    chk("rst_cyc",     int'(cyc),     0);
    chk("rst_pos",     int'(pos_stb), 0);
    @(negedge clk);
    rst_n = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    chk("idle_clk_out", int'(clk_out), 0);

    run_case(1'b0, 1, 5, 12, 16);
    run_case(1'b0, 3, 2, 10, 14);
    run_case(1'b0, 0, 3, 8, 10);
    run_case(1'b0, 4, 0, 1, 12);
    run_case(1'b0, 2, 3, 10, 16);
    run_case(1'b0, 3, 0, 7, 14);
    run_case(1'b1, 1, 0, 81, 90);

    for (int i = 0; i < 12; i++) begin
      run_case(1'b0, int'($urandom_range(0, 5)), int'($urandom_range(0, 4)),
               int'($urandom_range(1, 40)), 48);
    end

    // Asynchronous reset in the middle of a high phase.
    @(negedge clk);
    div_half = 8'd4;
    max_cyc  = 16'd0;
    en       = 1'b1;
    @(posedge clk);
    @(posedge clk);
    #3;
    chk("pre_rst_clk_out", int'(clk_out), 1);
    chk("pre_rst_cyc",     int'(cyc),     1);
    rst_n = 1'b0;
    #1;
    chk("async_clk_out", int'(clk_out), 0);
    chk("async_done",    int'(done),    0);
    chk("async_cyc",     int'(cyc),     0);
    en = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    for (int i = 0; i < 5; i++) begin
      @(posedge clk);
      #1;
      chk("post_rst_clk_out", int'(clk_out), 0);
      chk("post_rst_pos",     int'(pos_stb), 0);
      chk("post_rst_cyc",     int'(cyc),     0);
    end
    run_case(1'b0, 2, 2, 20, 12);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
